e_mdu_ctrl: RTL and testbench

- Multiply/divide sequencer in the E stage of the 5-stage MIPS pipeline.
- Accepts mult, multu, div and divu, and models their multi-cycle latency with a countdown counter.
- Owns the HI/LO registers and serves mfhi/mflo/mthi/mtlo.
- Generates the stall request that the hazard unit ORs into the D-stage freeze.

---
 rtl/e_mdu_ctrl_pkg.sv | 32 +++
 rtl/e_mdu_ctrl_calc.sv | 59 +++++
 rtl/e_mdu_ctrl.sv | 126 ++++++++++++
 tb/tb_e_mdu_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl_pkg
// Shared definitions for the E-stage multiply/divide unit: MDU operation
// codes, default busy latencies and small op-classification helpers.
// ---------------------------------------------------------------------------
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // True for the four ops that launch a multi-cycle operation.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_calc.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl_calc
// Purely combinational MDU arithmetic.
// Ports:
//   i_op           MDU op code (only mult/multu/div/divu produce a result)
//   i_rs, i_rt     32-bit operands (rs = multiplicand / dividend)
//   o_res          {hi, lo}: 64-bit product, or {remainder, quotient}
//   o_div_by_zero  div/divu with rt == 0; result must not be committed
// ---------------------------------------------------------------------------
module e_mdu_ctrl_calc
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_res,
  output logic        o_div_by_zero
);

  logic        [63:0] u_prod;
  logic signed [63:0] s_prod;
  logic               rt_zero;
  logic               s_ovf;
  logic        [31:0] u_rt_safe;
  logic signed [31:0] s_rt_safe;
  logic        [31:0] u_q, u_r;
  logic signed [31:0] s_q, s_r;

  assign u_prod = {32'd0, i_rs} * {32'd0, i_rt};
  assign s_prod = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});

  assign rt_zero = (i_rt == 32'd0);
  assign s_ovf   = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  // A zero divisor is replaced by 1 so the dividers never see /0; the result
  // is discarded anyway. For the signed overflow case, dividing by 1 yields
  // exactly the required quotient 0x80000000 with remainder 0.
  assign u_rt_safe = rt_zero ? 32'd1 : i_rt;
  assign s_rt_safe = (rt_zero || s_ovf) ? 32'sd1 : $signed(i_rt);

  assign u_q = i_rs / u_rt_safe;
  assign u_r = i_rs % u_rt_safe;
  assign s_q = $signed(i_rs) / s_rt_safe;
  assign s_r = $signed(i_rs) % s_rt_safe;

  always_comb begin
    o_res = 64'd0;
    case (i_op)
      MD_MULT:  o_res = s_prod;
      MD_MULTU: o_res = u_prod;
      MD_DIV:   o_res = {s_r, s_q};
      MD_DIVU:  o_res = {u_r, u_q};
      default:  o_res = 64'd0;
    endcase
  end

  assign o_div_by_zero = is_md_div(i_op) && rt_zero;

endmodule

// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl
// E-stage multiply/divide sequencer. Latches the result of mult/multu/div/
// divu at start, models the unit latency with a countdown, then commits the
// result to HI/LO. Serves mfhi/mflo/mthi/mtlo and raises the D-stage stall.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_md_op      E-stage MDU op (MD_NONE for non-MDU / bubble)
//   i_rs, i_rt   forwarded E-stage operands
//   i_D_is_md    D-stage instruction is an MDU instruction
//   o_busy       operation in flight
//   o_start      E-stage op launches a multi-cycle operation (comb.)
//   o_stall      freeze D stage
//   o_md_rdata   HI for mfhi, LO for mflo, else 0 (comb.)
//   o_hi, o_lo   architectural HI/LO
// ---------------------------------------------------------------------------
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_md_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_D_is_md,
  output logic        o_busy,
  output logic        o_start,
  output logic        o_stall,
  output logic [31:0] o_md_rdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      p_hi_q, p_hi_d;
  logic [31:0]      p_lo_q, p_lo_d;
  logic             p_ok_q, p_ok_d;

  logic [63:0]      calc_res;
  logic             calc_dbz;
  logic             last_cycle;

  e_mdu_ctrl_calc u_calc (
    .i_op          (i_md_op),
    .i_rs          (i_rs),
    .i_rt          (i_rt),
    .o_res         (calc_res),
    .o_div_by_zero (calc_dbz)
  );

  assign o_start    = is_md_start(i_md_op);
  assign last_cycle = busy_q && (cnt_q == CNT_W'(1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    p_ok_d = p_ok_q;
    if (busy_q) begin
      // A start seen here is ignored: the stall should have prevented it.
      cnt_d = cnt_q - 1'b1;
      if (last_cycle) begin
        busy_d = 1'b0;
        if (p_ok_q) begin
          hi_d = p_hi_q;
          lo_d = p_lo_q;
        end
      end
    end else if (o_start) begin
      p_hi_d = calc_res[63:32];
      p_lo_d = calc_res[31:0];
      p_ok_d = !calc_dbz;
      cnt_d  = is_md_div(i_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_d = 1'b1;
    end else if (i_md_op == MD_MTHI) begin
      hi_d = i_rs;
    end else if (i_md_op == MD_MTLO) begin
      lo_d = i_rs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      p_ok_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      p_ok_q <= p_ok_d;
    end
  end

  // The final busy cycle does not stall: HI/LO commit on the same edge that
  // moves the waiting D-stage op into E, so it already reads the new value.
  assign o_stall = i_D_is_md && (o_start || (busy_q && !last_cycle));

  always_comb begin
    o_md_rdata = 32'd0;
    if (i_md_op == MD_MFHI)      o_md_rdata = hi_q;
    else if (i_md_op == MD_MFLO) o_md_rdata = lo_q;
  end

  assign o_busy = busy_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_md_op;
  logic [31:0] i_rs, i_rt;
  logic        i_D_is_md;
  logic        o_busy, o_start, o_stall;
  logic [31:0] o_md_rdata, o_hi, o_lo;

  always #5 clk = ~clk;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_md_op    (i_md_op),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .i_D_is_md  (i_D_is_md),
    .o_busy     (o_busy),
    .o_start    (o_start),
    .o_stall    (o_stall),
    .o_md_rdata (o_md_rdata),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: architectural HI/LO plus the pending result and the
  // index of the last cycle in which the unit is busy.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pok = 0;
  int          m_end = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_calc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit ok);
    longint      a, b, q, r;
    logic [63:0] p;
    ok = 1; hi = 0; lo = 0;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      MD_MULTU: begin p = {32'd0, rs} * {32'd0, rt}; hi = p[63:32]; lo = p[31:0]; end
      MD_MULT:  begin p = a * b; hi = p[63:32]; lo = p[31:0]; end
      MD_DIVU:  if (rt == 0) ok = 0; else begin lo = rs / rt; hi = rs % rt; end
      MD_DIV:   if (rt == 0) ok = 0; else begin q = a / b; r = a % b; lo = q[31:0]; hi = r[31:0]; end
      default:  ok = 0;
    endcase
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic dmd, input logic rst);
    bit          e_start, e_busy, e_stall;
    logic [31:0] e_rd;
    i_md_op = op; i_rs = rs; i_rt = rt; i_D_is_md = dmd; reset = rst;
    @(negedge clk);
    e_start = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    e_busy  = (cyc <= m_end);
    e_stall = dmd && (e_start || (cyc < m_end));
    e_rd    = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
    chk("start", {31'd0, o_start}, {31'd0, e_start});
    chk("busy",  {31'd0, o_busy},  {31'd0, e_busy});
    chk("stall", {31'd0, o_stall}, {31'd0, e_stall});
    chk("rdata", o_md_rdata, e_rd);
    chk("hi", o_hi, m_hi);
    chk("lo", o_lo, m_lo);
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_end = -1;
    end else if (e_busy) begin
      if (cyc == m_end && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (e_start) begin
      ref_calc(op, rs, rt, m_phi, m_plo, m_pok);
      m_end = cyc + (((op == MD_DIV) || (op == MD_DIVU)) ? DC : MC);
    end else if (op == MD_MTHI) begin
      m_hi = rs;
    end else if (op == MD_MTLO) begin
      m_lo = rs;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic dmd);
    for (int k = 0; k < n; k++) step(MD_NONE, 32'd0, 32'd0, dmd, 1'b0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; i_md_op = MD_NONE; i_rs = 0; i_rt = 0; i_D_is_md = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);

    // multu FFFFFFFF * 2
    step(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MC, 1'b0);
    chk("tp_multu_hi", o_hi, 32'h0000_0001);
    chk("tp_multu_lo", o_lo, 32'hFFFF_FFFE);

    // mult -3 * 7
    step(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    idle(MC, 1'b0);
    chk("tp_mult_hi", o_hi, 32'hFFFF_FFFF);
    chk("tp_mult_lo", o_lo, 32'hFFFF_FFEB);

    // div / divu -7, 2
    step(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("tp_div_lo", o_lo, 32'hFFFF_FFFD);
    chk("tp_div_hi", o_hi, 32'hFFFF_FFFF);
    step(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("tp_divu_lo", o_lo, 32'h7FFF_FFFC);
    chk("tp_divu_hi", o_hi, 32'h0000_0001);

    // signed overflow
    step(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("tp_ovf_lo", o_lo, 32'h8000_0000);
    chk("tp_ovf_hi", o_hi, 32'h0000_0000);

    // div with dependent mflo waiting in D
    step(MD_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(DC - 1, 1'b1);
    i_md_op = MD_NONE; i_D_is_md = 1'b1; #1;
    chk("tp_stall_drop", {31'd0, o_stall}, 32'd0);
    step(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0);
    i_md_op = MD_MFLO; i_D_is_md = 1'b0; #1;
    chk("tp_mflo", o_md_rdata, 32'd14);
    step(MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);

    // divu by zero leaves HI/LO alone
    step(MD_DIVU, 32'd55, 32'd0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("tp_dbz_hi", o_hi, 32'd2);
    chk("tp_dbz_lo", o_lo, 32'd14);

    // mthi then mfhi
    step(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    i_md_op = MD_MFHI; i_D_is_md = 1'b0; #1;
    chk("tp_mfhi", o_md_rdata, 32'h1234_5678);
    chk("tp_mfhi_stall", {31'd0, o_stall}, 32'd0);
    step(MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);

    // reset in busy cycle 3 of a div
    step(MD_DIV, 32'd1000, 32'd3, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("tp_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("tp_rst_hi", o_hi, 32'd0);
    chk("tp_rst_lo", o_lo, 32'd0);
    chk("tp_rst_stall", {31'd0, o_stall}, 32'd0);
    idle(DC + 2, 1'b1);
    chk("tp_rst_nocommit", o_lo, 32'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 2) == 0) op = MD_NONE;
      step(op, pick_val(), pick_val(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
